uart_boot_loader: RTL and testbench

//  Sits downstream of the UART receive path and consumes its byte stream.

---
 rtl/uart_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: packs received bytes into little-endian words, writes them to
// instruction memory and releases the CPU reset once the image is in. Optional checksum: UART_BOOT_CHECKSUM_EN.
module uart_boot_loader #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       MAX_WORDS = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        byte_in_i,
   input  logic              byte_ready_i,
   input  logic              restart_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic              cpu_rst_n_o,
   output logic [15:0]       words_done_o
);

   // state    | meaning
   // S_LEN_LO | waiting for word count low byte
   // S_LEN_HI | waiting for word count high byte
   // S_DATA   | collecting data bytes, one write per 4 bytes
   // S_CHK    | waiting for checksum byte (checksum build only)
   // S_DONE   | image loaded, CPU released
   // S_ERR    | bad length or checksum, CPU held in reset
   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
`ifdef UART_BOOT_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

`ifdef UART_BOOT_CHECKSUM_EN
   localparam state_t S_LAST = S_CHK;
`else
   localparam state_t S_LAST = S_DONE;
`endif

   state_t            state_q, state_d;
   logic              br_q;
   logic [15:0]       len_q, len_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       buf_q, buf_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       words_q, words_d;
   logic [15:0]       n_full;
   logic              acc;
`ifdef UART_BOOT_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_LEN_LO;
         br_q    <= 1'b0;
         len_q   <= '0;
         idx_q   <= '0;
         buf_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         addr_q  <= '0;
         words_q <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         br_q    <= byte_ready_i;
         len_q   <= len_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         words_q <= words_d;
`ifdef UART_BOOT_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      acc     = byte_ready_i & ~br_q;
      n_full  = {byte_in_i, len_q[7:0]};
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      words_d = words_q;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_LEN_LO: begin
            if (acc) begin
               len_d[7:0] = byte_in_i;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (acc) begin
               len_d = n_full;
               if (n_full == 16'd0)                state_d = S_LAST;
               else if (32'(n_full) > MAX_WORDS)   state_d = S_ERR;
               else                                state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (acc) begin
`ifdef UART_BOOT_CHECKSUM_EN
               csum_d = csum_q + byte_in_i;
`endif
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: buf_d[7:0]   = byte_in_i;
                  2'd1: buf_d[15:8]  = byte_in_i;
                  2'd2: buf_d[23:16] = byte_in_i;
                  default: begin
                     // Fourth byte goes straight into the write data register.
                     we_d    = 1'b1;
                     wdata_d = {byte_in_i, buf_q};
                     addr_d  = BASE_ADDR + ADDR_W'({words_q, 2'b00});
                     words_d = words_q + 16'd1;
                     if (words_q + 16'd1 == len_q) state_d = S_LAST;
                  end
               endcase
            end
         end
`ifdef UART_BOOT_CHECKSUM_EN
         S_CHK: begin
            if (acc) state_d = (byte_in_i == csum_q) ? S_DONE : S_ERR;
         end
`endif
         S_DONE, S_ERR: begin
            if (restart_i) begin
               state_d = S_LEN_LO;
               words_d = '0;
               idx_d   = '0;
`ifdef UART_BOOT_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         default: state_d = S_LEN_LO;
      endcase
   end

   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign words_done_o = words_q;
   assign done_o       = (state_q == S_DONE);
   assign error_o      = (state_q == S_ERR);
   assign cpu_rst_n_o  = (state_q == S_DONE);
`ifdef UART_BOOT_CHECKSUM_EN
   assign busy_o = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHK);
`else
   assign busy_o = (state_q == S_LEN_HI) || (state_q == S_DATA);
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes queued from a frame model,
// a negedge monitor pops and compares each memory write.
module tb_uart_boot_loader;
   localparam logic [31:0] BASE = 32'h100;
`ifdef UART_BOOT_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic [7:0]  byte_in_i = 8'h00;
   logic        byte_ready_i = 1'b0;
   logic        restart_i = 1'b0;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        busy_o, done_o, error_o, cpu_rst_n_o;
   logic [15:0] words_done_o;

   uart_boot_loader #(.ADDR_W(32), .BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
      .clk_i(clk), .rst_i(rst_i), .byte_in_i(byte_in_i), .byte_ready_i(byte_ready_i),
      .restart_i(restart_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .cpu_rst_n_o(cpu_rst_n_o), .words_done_o(words_done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] wd;
      bit          last;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] frame_q[$];
   int         checks = 0;
   int         errors = 0;
   int         we_cnt = 0;
   logic       prev_we = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we_o) begin
         we_cnt++;
         chk("we_back_to_back", prev_we, 1'b0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write",
                     mem_addr_o, mem_wdata_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", mem_addr_o, mon_e.addr);
            chk("wr_data", mem_wdata_o, mon_e.data);
            chk("wr_words_done", words_done_o, mon_e.wd);
            chk("wr_done_flag", done_o, mon_e.last && !CSUM);
         end
      end
      prev_we = mem_we_o;
   end

   // Frame model: length, little-endian data bytes, optional checksum (+cdelta to corrupt it).
   task automatic build(input logic [31:0] ws[$], input int npush, input logic [7:0] cdelta);
      logic [7:0] s;
      logic [7:0] bb;
      int n;
      s = 8'h00;
      n = ws.size();
      frame_q.delete();
      frame_q.push_back(n[7:0]);
      frame_q.push_back(n[15:8]);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) begin
            bb = ws[i][8*b +: 8];
            frame_q.push_back(bb);
            s = s + bb;
         end
         if (i < npush)
            exp_q.push_back('{BASE + 32'(i) * 32'd4, ws[i], 16'(i + 1), (i == n - 1)});
      end
      if (CSUM) frame_q.push_back(s + cdelta);
   endtask

   task automatic send(input int count, input int hold);
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         byte_in_i    = frame_q[i];
         byte_ready_i = 1'b1;
         repeat (hold) @(negedge clk);
         byte_ready_i = 1'b0;
         byte_in_i    = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic status(input string tag, input bit d, input bit e, input bit b,
                         input bit cr, input logic [15:0] wd);
      repeat (3) @(negedge clk);
      chk({tag, ":done"}, done_o, d);
      chk({tag, ":error"}, error_o, e);
      chk({tag, ":busy"}, busy_o, b);
      chk({tag, ":cpu_rst_n"}, cpu_rst_n_o, cr);
      chk({tag, ":words_done"}, words_done_o, wd);
      chk({tag, ":pending_writes"}, exp_q.size(), 0);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart_i = 1'b1;
      @(negedge clk);
      restart_i = 1'b0;
   endtask

   initial begin
      logic [31:0] ws[$];
      logic [31:0] empty_ws[$];
      int          w0;
      int          n;

      repeat (3) @(negedge clk);
      chk("rst:mem_we", mem_we_o, 0);
      chk("rst:mem_addr", mem_addr_o, 0);
      chk("rst:mem_wdata", mem_wdata_o, 0);
      chk("rst:busy", busy_o, 0);
      chk("rst:done", done_o, 0);
      chk("rst:error", error_o, 0);
      chk("rst:cpu_rst_n", cpu_rst_n_o, 0);
      chk("rst:words_done", words_done_o, 0);
      rst_i = 1'b1;
      @(negedge clk);

      ws = '{32'h44332211, 32'hDDCCBBAA};
      build(ws, 2, 8'h00);
      send(frame_q.size(), 1);
      status("t1", 1, 0, 0, 1, 16'd2);
      do_restart();
      status("t1_restart", 0, 0, 0, 0, 16'd0);

      w0 = we_cnt;
      build(ws, 2, 8'h00);
      send(frame_q.size(), 20);
      status("t2", 1, 0, 0, 1, 16'd2);
      chk("t2:we_pulses", we_cnt - w0, 2);
      do_restart();

      frame_q.delete();
      frame_q.push_back(8'h01);
      frame_q.push_back(8'h04);
      send(2, 1);
      status("t3_err", 0, 1, 0, 0, 16'd0);
      do_restart();
      build(ws, 2, 8'h00);
      send(frame_q.size(), 1);
      status("t3_retry", 1, 0, 0, 1, 16'd2);
      do_restart();

      build(ws, 1, 8'h00);
      send(8, 1);
      @(negedge clk);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      status("t4_reset", 0, 0, 0, 0, 16'd0);
      build(ws, 2, 8'h00);
      send(frame_q.size(), 2);
      status("t4_resend", 1, 0, 0, 1, 16'd2);
      do_restart();

      build(empty_ws, 0, 8'h00);
`ifdef UART_BOOT_CHECKSUM_EN
      send(2, 1);
      status("t5_wait_chk", 0, 0, 1, 0, 16'd0);
      frame_q.delete(0);
      frame_q.delete(0);
`endif
      send(frame_q.size(), 1);
      status("t5_zero", 1, 0, 0, 1, 16'd0);
      do_restart();

`ifdef UART_BOOT_CHECKSUM_EN
      ws = '{32'h04030201};
      build(ws, 1, 8'h00);
      send(frame_q.size(), 1);
      status("t6_good", 1, 0, 0, 1, 16'd1);
      do_restart();
      build(ws, 1, 8'h01);
      send(frame_q.size(), 1);
      status("t6_bad", 0, 1, 0, 0, 16'd1);
      do_restart();
`endif

      for (int it = 0; it < 5; it++) begin
         n = $urandom_range(1, 6);
         ws.delete();
         for (int i = 0; i < n; i++) ws.push_back($urandom);
         build(ws, n, 8'h00);
         send(frame_q.size(), $urandom_range(1, 4));
         status("rand", 1, 0, 0, 1, 16'(n));
         do_restart();
      end

      repeat (3) @(negedge clk);
      chk("final:pending_writes", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
